tx_uart: RTL

//   UART transmitter; the counterpart of the board-facing UART receiver.

---
 rtl/uart_pkg.sv | 16 +
 rtl/tx_uart_if.sv | 13 +
 rtl/tx_uart_fifo.sv | 65 ++++++
 rtl/tx_uart.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, idle line level and
// the default baud divisor used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;

  // 100 MHz system clock at 115200 baud
  localparam int CLOCKS_PER_BAUD_DEFAULT = 868;

endpackage

// File: rtl/tx_uart_if.sv
// Valid/ready byte handshake from the fabric into the UART transmitter.
interface tx_uart_if #(
  parameter int DW = 8
);

  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;

  modport master (output i_valid, output i_data, input o_ready);
  modport slave  (input i_valid, input i_data, output o_ready);

endinterface

// File: rtl/tx_uart_fifo.sv
// Small input FIFO for the UART transmitter; same-cycle push and pop allowed
// at any occupancy, ready is registered from the next-cycle occupancy.
module tx_uart_fifo #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic                          push,
  input  logic [DW-1:0]                 push_data,
  input  logic                          pop,
  output logic [DW-1:0]                 pop_data,
  output logic                          full,
  output logic                          empty,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Ready looks at the next occupancy so a push into the last slot drops it in time
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      ready <= (count_next != FULL_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/tx_uart.sv
// UART transmitter: FIFO-buffered bytes serialised 8N1, LSB first.
// Define TX_UART_PARITY_EN to insert an even-parity bit after the data bits.
module tx_uart
  import uart_pkg::*;
#(
  parameter int DW              = 8,
  parameter int TIMER_BITS      = 32,
  parameter int CLOCKS_PER_BAUD = CLOCKS_PER_BAUD_DEFAULT,
  parameter int FIFO_DEPTH      = 4,
  parameter int STOP_BITS       = 1
) (
  input  logic                         clk,
  input  logic                         i_reset,
  tx_uart_if.slave                     bus,
  output logic                         o_busy,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
  output logic                         uart_rxd_out
);

  localparam int IW = $clog2(DW);
  localparam logic [TIMER_BITS-1:0] BAUD_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DW - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  logic [2:0]            state;
  logic [TIMER_BITS-1:0] baud_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DW-1:0]         shift_q;
  logic                  parity_q;
  logic                  line_q;

  logic                  baud_done;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_ready;
  logic [DW-1:0]         fifo_data;

  assign baud_done = (baud_cnt == '0);
  assign fifo_push = bus.i_valid && fifo_ready && !fifo_full;
  // Pop when idle, or on the last stop-bit cycle so the next start bit follows with no gap
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) ||
                      (state == ST_STOP && baud_done && bit_idx == LAST_STOP));

  assign bus.o_ready  = fifo_ready;
  assign o_busy       = (state != ST_IDLE) || !fifo_empty;
  assign uart_rxd_out = line_q;

  tx_uart_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .i_reset   (i_reset),
    .push      (fifo_push),
    .push_data (bus.i_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ready     (fifo_ready),
    .count     (o_fifo_count)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      baud_cnt <= BAUD_RELOAD;
      bit_idx  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      line_q   <= LINE_IDLE;
    end else begin
      if (fifo_pop) begin
        shift_q  <= fifo_data;
        parity_q <= ^fifo_data;
      end
      case (state)
        ST_IDLE: begin
          line_q   <= LINE_IDLE;
          baud_cnt <= BAUD_RELOAD;
          bit_idx  <= '0;
          if (fifo_pop) begin
            state  <= ST_START;
            line_q <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_done) begin
            state    <= ST_DATA;
            line_q   <= shift_q[0];
            bit_idx  <= '0;
            baud_cnt <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef TX_UART_PARITY_EN
              state   <= ST_PARITY;
              line_q  <= parity_q;
`else
              state   <= ST_STOP;
              line_q  <= LINE_IDLE;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift_q <= shift_q >> 1;
              line_q  <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_PARITY: begin
          line_q <= parity_q;
          if (baud_done) begin
            state    <= ST_STOP;
            line_q   <= LINE_IDLE;
            bit_idx  <= '0;
            baud_cnt <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              if (fifo_pop) begin
                state  <= ST_START;
                line_q <= 1'b0;
              end else begin
                state  <= ST_IDLE;
                line_q <= LINE_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          line_q <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule
